nbit_magnitude_comparator: RTL and testbench
============================================

# nbit_magnitude_comparator

Registered, parameterizable unsigned magnitude comparator. It compares two N-bit operands A and B and reports exactly one of less-than, greater-than or equal. The result appears a fixed two cycles after the operands are sampled. It sits in datapaths that need a pipelined compare result qualified by a valid strobe, such as sorters, limit checkers and arbiters.

## Interface
- N, default 8: operand width in bits; any value ≥ 1 is legal; the bench uses N=10.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- in_valid  input  1  A/B are sampled on a clk edge where in_valid=1.
- L_T  output  1  result: A < B.
- G_T  output  1  result: A > B.
- E  output  1  result: A == B.
- out_valid  output  1  L_T/G_T/E hold a valid result this cycle.

## Operation
- Compare A and B as unsigned integers; there is no signed mode.
- Stage 1, input register:
  - on a clk edge with in_valid=1, capture A and B into a_q and b_q, and set v1=1;
  - with in_valid=0, set v1=0 and leave a_q/b_q unchanged.
- Compare logic (combinational between the stages), built as a tree rather than a single `<` operator:
  - per-bit terms: gt_i = a_i & ~b_i; eq_i = ~(a_i ^ b_i);
  - merge adjacent groups with the higher group dominant: gt = gt_hi | (eq_hi & gt_lo); eq = eq_hi & eq_lo;
  - tree depth is ceil(log2 N);
  - an odd group at any level passes through unchanged;
  - lt = ~gt & ~eq.
- Stage 2, output register: on every clk edge, L_T←lt, G_T←gt, E←eq and out_valid←v1.
- When out_valid=1, exactly one of L_T, G_T, E is 1. This one-hot property is an invariant.
- When out_valid=0, L_T/G_T/E hold their previous values. Consumers ignore them in this state.
- For N=1, the tree reduces to the single bit-level term.

## Timing
- Latency: operands sampled at edge k produce a result and out_valid=1 after edge k+1.
  - Equivalently, the result is visible during the cycle that follows two sampling edges.
- Throughput: one compare per cycle. Back-to-back in_valid=1 yields back-to-back out_valid=1 with no bubbles.
- There is no backpressure; out_valid is a single-cycle strobe per accepted operand pair.
- Reset (rst_n=0, asynchronous, effective immediately without a clock):
  - a_q=0, b_q=0, v1=0;
  - L_T=0, G_T=0, E=0, out_valid=0.
- While rst_n=0, all outputs stay at their reset values regardless of inputs.
- Reset mid-operation: in-flight operands are discarded and out_valid=0 is forced immediately.
- After rst_n deasserts, the first valid result appears two edges after the first edge with in_valid=1.
- A/B/in_valid changing between edges has no effect on the outputs.

## Test plan
- N=10, A=60, B=61, in_valid=1 for one cycle -> two edges later: L_T=1, G_T=0, E=0, out_valid=1 for one cycle.
- N=10, A=51, B=47 -> G_T=1, L_T=0, E=0. Then A=42, B=42 on the next cycle -> E=1, L_T=0, G_T=0 one cycle later, with out_valid held high across both cycles.
- N=10 extremes:
  - A=0, B=1023 -> L_T=1;
  - A=1023, B=0 -> G_T=1;
  - A=B=1023 -> E=1;
  - A=512, B=511 (MSB decides) -> G_T=1.
- Reset: drive valid pairs continuously, then pull rst_n=0 mid-stream -> outputs and out_valid go to 0 immediately without waiting for clk. After release, no out_valid until two edges after the next in_valid=1.
- in_valid gaps: pattern 1,0,1 with pairs (5,9) then (9,5) -> out_valid pattern 1,0,1 with L_T then G_T. Outputs hold during the gap.
- Random regression, N=1, 7 and 10, 10k pairs:
  - each result matches the unsigned reference compare, delayed 2 cycles;
  - one-hot holds on every cycle with out_valid=1.

Source files
------------

// File: rtl/nbit_magnitude_comparator.sv
// Two-stage registered unsigned magnitude comparator: input register, a
// dominance-merge compare tree, then a registered one-hot result with valid.
module nbit_magnitude_comparator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         in_valid,
  output logic         L_T,
  output logic         G_T,
  output logic         E,
  output logic         out_valid
);

  localparam int DEPTH = (N > 1) ? $clog2(N) : 0;

  // Number of groups at a tree level; odd leftovers pass through, so round up.
  function automatic int cnt_at(input int lvl);
    int c;
    c = N;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         v1;
  logic         cmp_gt;
  logic         cmp_eq;
  logic         cmp_lt;

  // Valid semantics: a pair is accepted on every edge with in_valid=1; there is
  // no ready, and out_valid is a one-cycle strobe two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_q <= A;
        b_q <= B;
      end
    end
  end

  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    localparam int C = cnt_at(l);
    logic [C-1:0] gt;
    logic [C-1:0] eq;
    if (l == 0) begin : g_leaf
      assign gt = a_q & ~b_q;
      assign eq = ~(a_q ^ b_q);
    end else begin : g_merge
      localparam int PC = cnt_at(l - 1);
      for (genvar j = 0; j < C; j++) begin : g_node
        if (2 * j + 1 < PC) begin : g_pair
          // The more significant group decides unless it is equal.
          assign gt[j] = g_lvl[l-1].gt[2*j+1] | (g_lvl[l-1].eq[2*j+1] & g_lvl[l-1].gt[2*j]);
          assign eq[j] = g_lvl[l-1].eq[2*j+1] & g_lvl[l-1].eq[2*j];
        end else begin : g_pass
          assign gt[j] = g_lvl[l-1].gt[2*j];
          assign eq[j] = g_lvl[l-1].eq[2*j];
        end
      end
    end
  end

  assign cmp_gt = g_lvl[DEPTH].gt[0];
  assign cmp_eq = g_lvl[DEPTH].eq[0];
  assign cmp_lt = ~cmp_gt & ~cmp_eq;

  // Results load only alongside a valid strobe so they hold through gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      L_T       <= 1'b0;
      G_T       <= 1'b0;
      E         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        L_T <= cmp_lt;
        G_T <= cmp_gt;
        E   <= cmp_eq;
      end
    end
  end

endmodule

// File: tb/tb_nbit_magnitude_comparator.sv
// Bench for nbit_magnitude_comparator: directed spec scenarios on N=10 and a
// randomized regression on N=10, 7 and 1 against an arithmetic reference.
module tb_nbit_magnitude_comparator;

  typedef struct packed {
    logic v;
    logic lt;
    logic gt;
    logic eq;
  } rec_t;

  typedef struct packed {
    logic       v;
    logic [9:0] a;
    logic [9:0] b;
    logic       eov;
    logic       chk;
    logic [2:0] eres;
  } step_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] drv_a [3];
  logic [9:0] drv_b [3];
  logic       drv_v [3];
  logic       lt_o  [3];
  logic       gt_o  [3];
  logic       eq_o  [3];
  logic       ov_o  [3];

  rec_t exp_q [3][$];
  rec_t exp_r [3];
  rec_t last  [3];
  logic have_last [3];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset / DUTs ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  nbit_magnitude_comparator #(.N(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .A(drv_a[0]), .B(drv_b[0]), .in_valid(drv_v[0]),
    .L_T(lt_o[0]), .G_T(gt_o[0]), .E(eq_o[0]), .out_valid(ov_o[0])
  );
  nbit_magnitude_comparator #(.N(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .A(drv_a[1][6:0]), .B(drv_b[1][6:0]), .in_valid(drv_v[1]),
    .L_T(lt_o[1]), .G_T(gt_o[1]), .E(eq_o[1]), .out_valid(ov_o[1])
  );
  nbit_magnitude_comparator #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .A(drv_a[2][0:0]), .B(drv_b[2][0:0]), .in_valid(drv_v[2]),
    .L_T(lt_o[2]), .G_T(gt_o[2]), .E(eq_o[2]), .out_valid(ov_o[2])
  );

  // ---------------- driver + reference model ----------------
  // Records what was driven at this edge; the result of the edge before is
  // what the outputs must show one edge later.
  task automatic tick();
    rec_t r;
    for (int i = 0; i < 3; i++) begin
      r.v  = drv_v[i];
      r.lt = (drv_a[i] < drv_b[i]);
      r.gt = (drv_a[i] > drv_b[i]);
      r.eq = (drv_a[i] == drv_b[i]);
      exp_q[i].push_back(r);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() > 1) exp_r[i] = exp_q[i].pop_front();
      else exp_r[i] = '0;
      if (exp_r[i].v) begin
        last[i]      = exp_r[i];
        have_last[i] = 1'b1;
      end
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      drv_v[i] = 1'b0;
      drv_a[i] = '0;
      drv_b[i] = '0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({lt_o[i], gt_o[i], eq_o[i], ov_o[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got %b required 0000", i, {lt_o[i], gt_o[i], eq_o[i], ov_o[i]});
      end
    end
    drv_v[0] = 1'b1; drv_a[0] = 10'd5; drv_b[0] = 10'd3;
    @(posedge clk);
    #1;
    n_tests++;
    if ({lt_o[0], gt_o[0], eq_o[0], ov_o[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b required 0000", {lt_o[0], gt_o[0], eq_o[0], ov_o[0]});
    end
    #3;
    idle_all();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    step_t tbl [3];
    tbl[0] = '{1'b1, 10'd60, 10'd61, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b0, 10'd0,  10'd0,  1'b1, 1'b1, 3'b100};
    tbl[2] = '{1'b0, 10'd0,  10'd0,  1'b0, 1'b1, 3'b100};
    for (int k = 0; k < 3; k++) begin
      drv_v[0] = tbl[k].v; drv_a[0] = tbl[k].a; drv_b[0] = tbl[k].b;
      tick();
      n_tests++;
      if (ov_o[0] !== tbl[k].eov) begin
        n_fail++;
        $display("FAIL basic out_valid step %0d: got %b required %b", k, ov_o[0], tbl[k].eov);
      end
      if (tbl[k].chk) begin
        n_tests++;
        if ({lt_o[0], gt_o[0], eq_o[0]} !== tbl[k].eres) begin
          n_fail++;
          $display("FAIL basic lt/gt/eq step %0d: got %b required %b", k, {lt_o[0], gt_o[0], eq_o[0]}, tbl[k].eres);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t tbl [4];
    tbl[0] = '{1'b1, 10'd51, 10'd47, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 10'd42, 10'd42, 1'b1, 1'b1, 3'b010};
    tbl[2] = '{1'b0, 10'd0,  10'd0,  1'b1, 1'b1, 3'b001};
    tbl[3] = '{1'b0, 10'd0,  10'd0,  1'b0, 1'b1, 3'b001};
    for (int k = 0; k < 4; k++) begin
      drv_v[0] = tbl[k].v; drv_a[0] = tbl[k].a; drv_b[0] = tbl[k].b;
      tick();
      n_tests++;
      if (ov_o[0] !== tbl[k].eov) begin
        n_fail++;
        $display("FAIL back_to_back out_valid step %0d: got %b required %b", k, ov_o[0], tbl[k].eov);
      end
      if (tbl[k].chk) begin
        n_tests++;
        if ({lt_o[0], gt_o[0], eq_o[0]} !== tbl[k].eres) begin
          n_fail++;
          $display("FAIL back_to_back lt/gt/eq step %0d: got %b required %b", k, {lt_o[0], gt_o[0], eq_o[0]}, tbl[k].eres);
        end
      end
    end
  endtask

  task automatic test_extremes();
    step_t tbl [6];
    tbl[0] = '{1'b1, 10'd0,    10'd1023, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 10'd1023, 10'd0,    1'b1, 1'b1, 3'b100};
    tbl[2] = '{1'b1, 10'd1023, 10'd1023, 1'b1, 1'b1, 3'b010};
    tbl[3] = '{1'b1, 10'd512,  10'd511,  1'b1, 1'b1, 3'b001};
    tbl[4] = '{1'b0, 10'd0,    10'd0,    1'b1, 1'b1, 3'b010};
    tbl[5] = '{1'b0, 10'd0,    10'd0,    1'b0, 1'b1, 3'b010};
    for (int k = 0; k < 6; k++) begin
      drv_v[0] = tbl[k].v; drv_a[0] = tbl[k].a; drv_b[0] = tbl[k].b;
      tick();
      n_tests++;
      if (ov_o[0] !== tbl[k].eov) begin
        n_fail++;
        $display("FAIL extremes out_valid step %0d: got %b required %b", k, ov_o[0], tbl[k].eov);
      end
      if (tbl[k].chk) begin
        n_tests++;
        if ({lt_o[0], gt_o[0], eq_o[0]} !== tbl[k].eres) begin
          n_fail++;
          $display("FAIL extremes lt/gt/eq step %0d: got %b required %b", k, {lt_o[0], gt_o[0], eq_o[0]}, tbl[k].eres);
        end
      end
    end
  endtask

  task automatic test_gaps();
    step_t tbl [5];
    tbl[0] = '{1'b1, 10'd5, 10'd9, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 3'b100};
    tbl[2] = '{1'b1, 10'd9, 10'd5, 1'b0, 1'b1, 3'b100};
    tbl[3] = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 3'b010};
    tbl[4] = '{1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 3'b010};
    for (int k = 0; k < 5; k++) begin
      drv_v[0] = tbl[k].v; drv_a[0] = tbl[k].a; drv_b[0] = tbl[k].b;
      tick();
      n_tests++;
      if (ov_o[0] !== tbl[k].eov) begin
        n_fail++;
        $display("FAIL gaps out_valid step %0d: got %b required %b", k, ov_o[0], tbl[k].eov);
      end
      if (tbl[k].chk) begin
        n_tests++;
        if ({lt_o[0], gt_o[0], eq_o[0]} !== tbl[k].eres) begin
          n_fail++;
          $display("FAIL gaps lt/gt/eq step %0d: got %b required %b", k, {lt_o[0], gt_o[0], eq_o[0]}, tbl[k].eres);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drv_v[0] = 1'b1;
      drv_a[0] = 10'($urandom_range(0, 1023));
      drv_b[0] = 10'($urandom_range(0, 1023));
      tick();
      if (k > 0) begin
        n_tests++;
        if (ov_o[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_mid stream out_valid step %0d: got %b required 1", k, ov_o[0]);
        end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({lt_o[i], gt_o[i], eq_o[i], ov_o[i]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid async inst%0d: got %b required 0000", i, {lt_o[i], gt_o[i], eq_o[i], ov_o[i]});
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({lt_o[0], gt_o[0], eq_o[0], ov_o[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid held: got %b required 0000", {lt_o[0], gt_o[0], eq_o[0], ov_o[0]});
    end
    #3;
    idle_all();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      have_last[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (ov_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid idle out_valid step %0d: got %b required 0", k, ov_o[0]);
      end
    end
    drv_v[0] = 1'b1; drv_a[0] = 10'd3; drv_b[0] = 10'd7;
    tick();
    n_tests++;
    if (ov_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid first edge out_valid: got %b required 0", ov_o[0]);
    end
    drv_v[0] = 1'b0;
    tick();
    n_tests++;
    if ({lt_o[0], gt_o[0], eq_o[0], ov_o[0]} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_mid first result: got %b required 1001", {lt_o[0], gt_o[0], eq_o[0], ov_o[0]});
    end
    tick();
  endtask

  task automatic test_random();
    int w;
    int maxv;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 3; i++) begin
        w = (i == 0) ? 10 : (i == 1) ? 7 : 1;
        maxv = (1 << w) - 1;
        drv_v[i] = ($urandom_range(0, 3) != 0);
        drv_a[i] = 10'($urandom_range(0, maxv));
        drv_b[i] = ($urandom_range(0, 3) == 0) ? drv_a[i] : 10'($urandom_range(0, maxv));
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (ov_o[i] !== exp_r[i].v) begin
          n_fail++;
          $display("FAIL random out_valid inst%0d iter %0d: got %b required %b", i, n, ov_o[i], exp_r[i].v);
        end
        if (have_last[i]) begin
          n_tests++;
          if ({lt_o[i], gt_o[i], eq_o[i]} !== {last[i].lt, last[i].gt, last[i].eq}) begin
            n_fail++;
            $display("FAIL random lt/gt/eq inst%0d iter %0d: got %b required %b", i, n,
                     {lt_o[i], gt_o[i], eq_o[i]}, {last[i].lt, last[i].gt, last[i].eq});
          end
        end
        if (ov_o[i] === 1'b1) begin
          n_tests++;
          if ((32'(lt_o[i]) + 32'(gt_o[i]) + 32'(eq_o[i])) != 1) begin
            n_fail++;
            $display("FAIL random one_hot inst%0d iter %0d: got %b required exactly one set", i, n,
                     {lt_o[i], gt_o[i], eq_o[i]});
          end
        end
      end
    end
    idle_all();
    tick();
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    idle_all();
    for (int i = 0; i < 3; i++) have_last[i] = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
